// File: rtl/vip_flatten_pkg.sv
// rtl/vip_flatten_pkg.sv - shared geometry and FSM state type for the flatten/unflatten cores
package vip_flatten_pkg;

  localparam int DWIDTH       = 32;
  localparam int NCH          = 16;
  localparam int FRAME_PIXELS = 784;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_WRITE   = 1'b1
  } state_t;

endpackage

// File: rtl/core_line_buffer_unflatten.sv
// rtl/core_line_buffer_unflatten.sv - gathers 16 interleaved stream words into one pixel and writes all channels at once
module core_line_buffer_unflatten #(
  parameter int DWIDTH       = vip_flatten_pkg::DWIDTH,
  parameter int NCH          = vip_flatten_pkg::NCH,
  parameter int FRAME_PIXELS = vip_flatten_pkg::FRAME_PIXELS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DWIDTH-1:0] ff_rdata,
  input  logic              ff_empty,
  output logic              ff_rdreq,
  output logic [DWIDTH-1:0] ff_wdata0,
  output logic [DWIDTH-1:0] ff_wdata1,
  output logic [DWIDTH-1:0] ff_wdata2,
  output logic [DWIDTH-1:0] ff_wdata3,
  output logic [DWIDTH-1:0] ff_wdata4,
  output logic [DWIDTH-1:0] ff_wdata5,
  output logic [DWIDTH-1:0] ff_wdata6,
  output logic [DWIDTH-1:0] ff_wdata7,
  output logic [DWIDTH-1:0] ff_wdata8,
  output logic [DWIDTH-1:0] ff_wdata9,
  output logic [DWIDTH-1:0] ff_wdata10,
  output logic [DWIDTH-1:0] ff_wdata11,
  output logic [DWIDTH-1:0] ff_wdata12,
  output logic [DWIDTH-1:0] ff_wdata13,
  output logic [DWIDTH-1:0] ff_wdata14,
  output logic [DWIDTH-1:0] ff_wdata15,
  output logic              ff_wrreq,
  input  logic              ff_full,
  output logic              frame_done
);
  import vip_flatten_pkg::state_t, vip_flatten_pkg::ST_COLLECT, vip_flatten_pkg::ST_WRITE;

  localparam int            PW       = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [PW-1:0] LAST_PIX = PW'(FRAME_PIXELS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [4:0]        r_issued;
  logic [3:0]        r_cap;
  logic              r_rd_valid;
  logic [PW-1:0]     r_pixel_cnt;
  logic [DWIDTH-1:0] r_slot [NCH];
  logic              w_last_cap;

  assign w_last_cap = r_rd_valid && (r_cap == 4'd15);

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_COLLECT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: if (w_last_cap) w_state_nxt = ST_WRITE;
      ST_WRITE:   if (!ff_full)   w_state_nxt = ST_COLLECT;
      default:    w_state_nxt = ST_COLLECT;
    endcase
  end

  // Requests are gated by reset so nothing leaks out before the state register settles.
  always_comb begin
    ff_rdreq = 1'b0;
    ff_wrreq = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_COLLECT: ff_rdreq = ~ff_empty & (r_issued < 5'd16);
        ST_WRITE:   ff_wrreq = ~ff_full;
        default:    ff_rdreq = 1'b0;
      endcase
    end
  end

  assign frame_done = ff_wrreq && (r_pixel_cnt == LAST_PIX);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_issued    <= '0;
      r_cap       <= '0;
      r_rd_valid  <= 1'b0;
      r_pixel_cnt <= '0;
    end else begin
      r_rd_valid <= ff_rdreq;
      if (ff_rdreq)   r_issued <= r_issued + 5'd1;
      if (r_rd_valid) r_cap    <= r_cap + 4'd1;
      if (ff_wrreq) begin
        r_issued    <= '0;
        r_cap       <= '0;
        r_pixel_cnt <= frame_done ? '0 : r_pixel_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) r_slot[i] <= '0;
    end else if (r_rd_valid) begin
      r_slot[r_cap] <= ff_rdata;
    end
  end

  assign ff_wdata0  = r_slot[0];
  assign ff_wdata1  = r_slot[1];
  assign ff_wdata2  = r_slot[2];
  assign ff_wdata3  = r_slot[3];
  assign ff_wdata4  = r_slot[4];
  assign ff_wdata5  = r_slot[5];
  assign ff_wdata6  = r_slot[6];
  assign ff_wdata7  = r_slot[7];
  assign ff_wdata8  = r_slot[8];
  assign ff_wdata9  = r_slot[9];
  assign ff_wdata10 = r_slot[10];
  assign ff_wdata11 = r_slot[11];
  assign ff_wdata12 = r_slot[12];
  assign ff_wdata13 = r_slot[13];
  assign ff_wdata14 = r_slot[14];
  assign ff_wdata15 = r_slot[15];

endmodule

// File: doc/core_line_buffer_unflatten.md
CORE_LINE_BUFFER_UNFLATTEN -- requirements
Module: core_line_buffer_unflatten

Interface
REQ-001 Parameter DWIDTH, default 32: word width of the upstream stream and of every channel word.
REQ-002 Parameter NCH, default 16: channels per pixel; fixed at 16 by the port list.
REQ-003 Parameter FRAME_PIXELS, default 784: pixels per frame (28x28).
REQ-004 Port clock, input, 1: single clock; all logic rising-edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port ff_rdata, input, DWIDTH: upstream FIFO read data, valid the cycle after ff_rdreq.
REQ-007 Port ff_empty, input, 1: upstream FIFO empty.
REQ-008 Port ff_rdreq, output, 1: upstream FIFO read request.
REQ-009 Ports ff_wdata0..ff_wdata15, output, DWIDTH each: channel words of one pixel to the 16 downstream channel FIFOs.
REQ-010 Port ff_wrreq, output, 1: shared write request to all 16 channel FIFOs.
REQ-011 Port ff_full, input, 1: any downstream channel FIFO (almost) full.
REQ-012 Port frame_done, output, 1: one-cycle pulse on the last pixel write of a frame.

Function
REQ-013 Block SHALL de-interleave the stream: words k*16+c, c=0..15, go to ff_wdata<c> of pixel k.
REQ-014 FSM SHALL have two states: COLLECT and WRITE.
REQ-015 In COLLECT, ff_rdreq SHALL be ~ff_empty & (issued < 16); issued is a 5-bit counter incremented on each ff_rdreq.
REQ-016 rd_valid SHALL be ff_rdreq registered by one cycle; on rd_valid, ff_rdata SHALL be captured into slot cap (4-bit), then cap increments.
REQ-017 When the capture into slot 15 occurs, state SHALL go to WRITE on that edge.
REQ-018 In WRITE, ff_rdreq SHALL be 0 and ff_wrreq SHALL be (state==WRITE) & ~ff_full, combinational.
REQ-019 In WRITE with ff_full=1, state, slots and ff_wdata SHALL hold unchanged.
REQ-020 In WRITE with ff_full=0, the block SHALL return to COLLECT next cycle with issued and cap cleared and increment pixel_cnt.
REQ-021 pixel_cnt SHALL count 0..FRAME_PIXELS-1; a write at FRAME_PIXELS-1 SHALL assert frame_done the same cycle and wrap pixel_cnt to 0.
REQ-022 ff_wdata<c> SHALL be the slot registers directly and remain stable from entry into WRITE until the write completes.
REQ-023 With upstream never empty and ff_full=0: first ff_rdreq cycle 0, ff_wrreq cycle 17, next ff_rdreq cycle 18 (one pixel per 18 cycles).
REQ-024 ff_empty gaps SHALL only stall ff_rdreq; capture order and slot mapping SHALL be unaffected.

Reset
REQ-025 On reset, state SHALL be COLLECT, and issued, cap, rd_valid, pixel_cnt and all slots SHALL be 0.
REQ-026 During and after reset, ff_rdreq, ff_wrreq and frame_done SHALL be 0 and every ff_wdata<c> SHALL be 0.
REQ-027 Reset mid-pixel SHALL discard the partial pixel; read data returning in the cycle after reset SHALL be ignored.

Structure
REQ-028 Shared package vip_flatten_pkg SHALL hold DWIDTH, NCH, FRAME_PIXELS and the FSM state type, shared with the flatten core.
REQ-029 The block SHALL be a leaf with no sub-modules; channel FIFOs are instantiated by the enclosing vip_top wrapper.

Verification
REQ-030 Reset then stream words 0..15, ff_full=0 -> ff_wrreq single pulse at cycle 17 with ff_wdata<c>=c; no frame_done.
REQ-031 Stream 16 words while ff_full=1 for 5 cycles after WRITE entry -> ff_wrreq stays 0 with data held for 5 cycles, then pulses once; ff_rdreq stays 0 throughout WRITE.
REQ-032 ff_empty toggling every other cycle over words 100..115 -> ff_wdata<c>=100+c, one ff_wrreq.
REQ-033 Stream 784*16 sequential words -> 784 ff_wrreq pulses and exactly one frame_done, coincident with the 784th write; a second frame gives a second frame_done.
REQ-034 Assert reset after 7 words captured, then stream 16 words of value 0xA0+c -> output pixel equals 0xA0+c, with no stale words.
REQ-035 Random ff_empty/ff_full over 50 pixels -> scoreboard matches exact de-interleave order, and no ff_rdreq is issued while ff_empty=1.
